// File: rtl/relay_mode_ctrl_pkg.sv
// ============================================================================
// Module  : relay_mode_ctrl_pkg
// Brief   : Shared codes and FSM states for the relay mode controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package relay_mode_ctrl_pkg;

    localparam logic [2:0] c_MOD_MASTER  = 3'b000;
    localparam logic [2:0] c_MOD_SLAVE   = 3'b001;
    localparam logic [2:0] c_MOD_DELAY   = 3'b010;

    localparam logic [1:0] c_REQ_LISTEN  = 2'b00;
    localparam logic [1:0] c_REQ_MEASURE = 2'b01;
    localparam logic [1:0] c_REQ_MASTER  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    // Reserved request 2'b11 behaves like listen.
    function automatic logic [2:0] idle_mod_type(input logic [1:0] req);
        return (req == c_REQ_MASTER) ? c_MOD_MASTER : c_MOD_SLAVE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/relay_mode_ctrl_if.sv
// ============================================================================
// Module  : relay_mode_ctrl_if
// Brief   : ARM/relay-facing signal bundle of the relay mode controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface relay_mode_ctrl_if #(
    parameter int CNT_W = 24
) ();
    logic [1:0]       mode_req;
    logic             start;
    logic             abort;
    logic             tx_start;
    logic             rx_done;
    logic [2:0]       mod_type;
    logic             busy;
    logic             done;
    logic             timed_out;
    logic [CNT_W-1:0] rtt_cycles;

    modport master (
        output mode_req, start, abort, tx_start, rx_done,
        input  mod_type, busy, done, timed_out, rtt_cycles
    );

    modport slave (
        input  mode_req, start, abort, tx_start, rx_done,
        output mod_type, busy, done, timed_out, rtt_cycles
    );
endinterface

`default_nettype wire

// File: rtl/relay_sat_counter.sv
// ============================================================================
// Module  : relay_sat_counter
// Brief   : Saturating up/down counter with clear, load and terminal flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module relay_sat_counter #(
    parameter int WIDTH = 24,
    parameter bit DOWN  = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_term_val,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_tc
);
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_step;
    logic             w_at_limit;

    generate
        if (DOWN) begin : g_down
            assign w_at_limit = (r_count == '0);
            assign w_step     = r_count - WIDTH'(1);
        end else begin : g_up
            assign w_at_limit = &r_count;
            assign w_step     = r_count + WIDTH'(1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_at_limit) begin
            r_count <= w_step;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_term_val);

endmodule

`default_nettype wire

// File: rtl/relay_mode_ctrl.sv
// ============================================================================
// Module  : relay_mode_ctrl
// Brief   : Sequences relay mod_type through one round-trip measurement.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module relay_mode_ctrl #(
    parameter int               CNT_W          = 24,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd8_000_000,
    parameter int unsigned      REPORT_CYCLES  = 1_048_576
) (
    input  wire logic         ck_1356meg,
    input  wire logic         rst_n,
    relay_mode_ctrl_if.slave  bus
);
    import relay_mode_ctrl_pkg::*;

    localparam int               c_RPT_W        = $clog2(REPORT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);
    localparam logic [c_RPT_W-1:0] c_RPT_LOAD   = c_RPT_W'(REPORT_CYCLES);
    localparam logic [c_RPT_W-1:0] c_RPT_LAST   = c_RPT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_mod_type, w_mod_type_nxt;
    logic             r_busy;
    logic             r_done, w_done_nxt;
    logic             r_timed_out, w_timed_out_nxt;
    logic [CNT_W-1:0] r_rtt, w_rtt_nxt;

    logic             w_rtt_clr, w_rtt_load, w_rtt_en, w_rtt_tc;
    logic [CNT_W-1:0] w_rtt_count;
    logic             w_rpt_load, w_rpt_en, w_rpt_tc;
    logic [c_RPT_W-1:0] w_unused_rpt_count;

    relay_sat_counter #(.WIDTH(CNT_W), .DOWN(1'b0)) u_rtt_cnt (
        .clk        (ck_1356meg),
        .rst_n      (rst_n),
        .i_clr      (w_rtt_clr),
        .i_load     (w_rtt_load),
        .i_load_val (c_CNT_ONE),
        .i_en       (w_rtt_en),
        .i_term_val (c_TIMEOUT_LAST),
        .o_count    (w_rtt_count),
        .o_tc       (w_rtt_tc)
    );

    relay_sat_counter #(.WIDTH(c_RPT_W), .DOWN(1'b1)) u_rpt_cnt (
        .clk        (ck_1356meg),
        .rst_n      (rst_n),
        .i_clr      (1'b0),
        .i_load     (w_rpt_load),
        .i_load_val (c_RPT_LOAD),
        .i_en       (w_rpt_en),
        .i_term_val (c_RPT_LAST),
        .o_count    (w_unused_rpt_count),
        .o_tc       (w_rpt_tc)
    );

    always_ff @(posedge ck_1356meg) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mod_type  <= c_MOD_SLAVE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            r_rtt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mod_type  <= w_mod_type_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_timed_out <= w_timed_out_nxt;
            r_rtt       <= w_rtt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_done_nxt      = 1'b0;
        w_timed_out_nxt = r_timed_out;
        w_rtt_nxt       = r_rtt;
        w_rtt_clr       = 1'b0;
        w_rtt_load      = 1'b0;
        w_rtt_en        = 1'b0;
        w_rpt_load      = 1'b0;
        w_rpt_en        = 1'b0;

        // Abort is tested first in every busy state so it beats any other event.
        case (r_state)
            ST_IDLE: begin
                if (bus.start && bus.mode_req == c_REQ_MEASURE) begin
                    w_state_nxt     = ST_ARMED;
                    w_timed_out_nxt = 1'b0;
                    w_rtt_clr       = 1'b1;
                end
            end
            ST_ARMED: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.tx_start) begin
                    w_state_nxt = ST_MEASURE;
                    w_rtt_load  = 1'b1;
                end
            end
            ST_MEASURE: begin
                w_rtt_en = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.rx_done) begin
                    w_state_nxt = ST_REPORT;
                    w_rtt_nxt   = w_rtt_count;
                    w_rpt_load  = 1'b1;
                end else if (w_rtt_tc) begin
                    w_state_nxt     = ST_REPORT;
                    w_timed_out_nxt = 1'b1;
                    w_rtt_nxt       = '1;
                    w_rpt_load      = 1'b1;
                end
            end
            ST_REPORT: begin
                w_rpt_en = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rpt_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        case (w_state_nxt)
            ST_ARMED, ST_MEASURE: w_mod_type_nxt = c_MOD_MASTER;
            ST_REPORT:            w_mod_type_nxt = c_MOD_DELAY;
            default:              w_mod_type_nxt = idle_mod_type(bus.mode_req);
        endcase
    end

    assign bus.mod_type   = r_mod_type;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.timed_out  = r_timed_out;
    assign bus.rtt_cycles = r_rtt;

endmodule

`default_nettype wire

// File: tb/tb_relay_mode_ctrl.sv
// ============================================================================
// Module  : tb_relay_mode_ctrl
// Brief   : Self-checking bench for relay_mode_ctrl with a report scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_relay_mode_ctrl;
    import relay_mode_ctrl_pkg::*;

    localparam int          CNT_W = 24;
    localparam logic [23:0] TO    = 24'd1000;
    localparam int          RPT   = 16;

    typedef struct {
        logic [CNT_W-1:0] rtt;
        logic             to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [2:0] prev_mod;
    int   delay_run = 0;
    int   done_cnt  = 0;

    always #5 clk = ~clk;

    relay_mode_ctrl_if #(.CNT_W(CNT_W)) bus ();

    relay_mode_ctrl #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TO),
        .REPORT_CYCLES  (RPT)
    ) dut (
        .ck_1356meg (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();  bus.start    = 1'b1; tick(); bus.start    = 1'b0; endtask
    task automatic do_tx();     bus.tx_start = 1'b1; tick(); bus.tx_start = 1'b0; endtask
    task automatic do_rx();     bus.rx_done  = 1'b1; tick(); bus.rx_done  = 1'b0; endtask
    task automatic do_abort();  bus.abort    = 1'b1; tick(); bus.abort    = 1'b0; endtask

    task automatic wait_done(input logic [2:0] exp_mod);
        int n = 0;
        while (bus.done !== 1'b1 && n < RPT + 50) begin
            tick();
            n++;
        end
        check_eq("done_seen", 32'(bus.done), 32'd1);
        check_eq("idle_mod_type", 32'(bus.mod_type), 32'(exp_mod));
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        tick();
        check_eq("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    // Scoreboard: each entry into DELAY consumes one expected result; done closes the window.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mod  = c_MOD_SLAVE;
            delay_run = 0;
        end else begin
            if (bus.mod_type == c_MOD_DELAY) begin
                if (prev_mod != c_MOD_DELAY) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected_report: rtt %0h with no pending result", bus.rtt_cycles);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("sb_rtt", 32'(bus.rtt_cycles), 32'(mon_e.rtt));
                        check_eq("sb_timed_out", 32'(bus.timed_out), 32'(mon_e.to));
                    end
                end
                delay_run++;
            end else begin
                if (bus.done) begin
                    done_cnt++;
                    check_eq("report_len", 32'(delay_run), 32'(RPT));
                end
                delay_run = 0;
            end
            prev_mod = bus.mod_type;
        end
    end

    initial begin
        int n;
        int d0;

        rst_n        = 1'b0;
        bus.mode_req = 2'($urandom);
        bus.start    = 1'($urandom);
        bus.abort    = 1'($urandom);
        bus.tx_start = 1'($urandom);
        bus.rx_done  = 1'($urandom);
        repeat (2) begin
            tick();
            bus.mode_req = 2'($urandom);
            bus.start    = 1'($urandom);
            bus.tx_start = 1'($urandom);
            bus.rx_done  = 1'($urandom);
        end
        check_eq("rst_mod_type", 32'(bus.mod_type), 32'(c_MOD_SLAVE));
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_rtt", 32'(bus.rtt_cycles), 32'd0);
        check_eq("rst_timed_out", 32'(bus.timed_out), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);

        bus.mode_req = c_REQ_LISTEN;
        bus.start = 1'b0; bus.abort = 1'b0; bus.tx_start = 1'b0; bus.rx_done = 1'b0;
        rst_n = 1'b1;
        tick();

        // Idle mode_req decoding and ignored starts
        bus.mode_req = c_REQ_MASTER; tick();
        check_eq("idle_forced_master", 32'(bus.mod_type), 32'(c_MOD_MASTER));
        bus.mode_req = 2'b11; tick();
        check_eq("idle_reserved", 32'(bus.mod_type), 32'(c_MOD_SLAVE));
        bus.mode_req = c_REQ_MASTER; do_start();
        check_eq("start_ignored_busy", 32'(bus.busy), 32'd0);
        check_eq("start_ignored_mod", 32'(bus.mod_type), 32'(c_MOD_MASTER));

        // Normal measurement, 500-cycle round trip with a stray tx_start
        bus.mode_req = c_REQ_MEASURE;
        do_start();
        check_eq("armed_busy", 32'(bus.busy), 32'd1);
        check_eq("armed_mod", 32'(bus.mod_type), 32'(c_MOD_MASTER));
        repeat (9) tick();
        do_tx();
        check_eq("measure_mod", 32'(bus.mod_type), 32'(c_MOD_MASTER));
        repeat (99) tick();
        do_tx();
        repeat (399) tick();
        exp_q.push_back('{rtt: 24'd500, to: 1'b0});
        do_rx();
        check_eq("report_mod", 32'(bus.mod_type), 32'(c_MOD_DELAY));
        check_eq("rtt_500", 32'(bus.rtt_cycles), 32'd500);
        wait_done(c_MOD_SLAVE);

        // Timeout without echo
        do_start();
        do_tx();
        exp_q.push_back('{rtt: 24'hFFFFFF, to: 1'b1});
        n = 0;
        while (bus.mod_type !== c_MOD_DELAY && n < 2000) begin
            tick();
            n++;
        end
        check_eq("timeout_edge", 32'(n), 32'(TO) - 32'd1);
        check_eq("timeout_flag", 32'(bus.timed_out), 32'd1);
        wait_done(c_MOD_SLAVE);
        check_eq("timeout_sticky", 32'(bus.timed_out), 32'd1);

        // Echo on the timeout cycle wins; mode_req change during measure takes effect at idle
        do_start();
        check_eq("start_clears_to", 32'(bus.timed_out), 32'd0);
        do_tx();
        exp_q.push_back('{rtt: 24'd999, to: 1'b0});
        repeat (998) tick();
        bus.mode_req = c_REQ_MASTER;
        do_rx();
        check_eq("rtt_999", 32'(bus.rtt_cycles), 32'd999);
        check_eq("race_no_timeout", 32'(bus.timed_out), 32'd0);
        wait_done(c_MOD_MASTER);
        bus.mode_req = c_REQ_MEASURE;
        tick();
        check_eq("idle_follows_req", 32'(bus.mod_type), 32'(c_MOD_SLAVE));

        // Abort three cycles into REPORT
        do_start();
        do_tx();
        repeat (122) tick();
        exp_q.push_back('{rtt: 24'd123, to: 1'b0});
        do_rx();
        tick();
        tick();
        d0 = done_cnt;
        do_abort();
        check_eq("abort_rpt_mod", 32'(bus.mod_type), 32'(c_MOD_SLAVE));
        check_eq("abort_rpt_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_rpt_done", 32'(bus.done), 32'd0);
        check_eq("abort_rpt_rtt", 32'(bus.rtt_cycles), 32'd123);
        repeat (RPT + 5) tick();
        check_eq("abort_rpt_no_done", 32'(done_cnt), 32'(d0));

        // Abort in ARMED
        do_start();
        do_abort();
        check_eq("abort_armed_busy", 32'(bus.busy), 32'd0);

        // Abort beats a simultaneous echo in MEASURE
        do_start();
        do_tx();
        repeat (50) tick();
        bus.abort = 1'b1; bus.rx_done = 1'b1;
        tick();
        bus.abort = 1'b0; bus.rx_done = 1'b0;
        check_eq("abort_rx_mod", 32'(bus.mod_type), 32'(c_MOD_SLAVE));
        check_eq("abort_rx_rtt", 32'(bus.rtt_cycles), 32'd123);
        check_eq("abort_rx_busy", 32'(bus.busy), 32'd0);

        // Reset mid-measurement
        do_start();
        do_tx();
        repeat (20) tick();
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrst_mod", 32'(bus.mod_type), 32'(c_MOD_SLAVE));
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_rtt", 32'(bus.rtt_cycles), 32'd0);
        repeat (5) tick();
        check_eq("midrst_no_done", 32'(done_cnt), 32'(d0));

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
